// File: rtl/mmio_mon_pkg.sv
// Shared types and default addresses for the MMIO end-of-test monitor.
package mmio_mon_pkg;

  typedef enum logic [1:0] {
    MON_RUN     = 2'd0,
    MON_PASS    = 2'd1,
    MON_FAIL    = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_status_t;

  localparam logic [31:0] MON_TOHOST_ADDR  = 32'd32;
  localparam logic [31:0] MON_SCRATCH_ADDR = 32'd16;

endpackage

// File: rtl/mon_sat_counter.sv
// Up-counter with enable and synchronous active-low clear; holds at all-ones.
module mon_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mmio_test_monitor.sv
// End-of-test monitor on the core's data-memory store bus; status visible one cycle after the store.
// Optional watchdog enabled by defining MMIO_MON_WATCHDOG_EN.
module mmio_test_monitor
  import mmio_mon_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = MON_TOHOST_ADDR,
  parameter logic [31:0] SCRATCH_ADDR   = MON_SCRATCH_ADDR,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic [1:0]       status,
  output logic [31:0]      err_adr,
  output logic [31:0]      err_data,
  output logic [CNT_W-1:0] cycles,
  output logic [15:0]      scratch_stores
);

  mon_status_t state;
  mon_status_t next_state;
  logic        wd_expire;
  logic        run_cnt_en;
  logic        scratch_en;
  logic        capture;

`ifdef MMIO_MON_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign wd_expire = (cycles == WD_LAST);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MON_RUN;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state != MON_RUN);
    end
  end

  // Bus decode is gated by MemWrite so address/data X never reaches state.
  always_comb begin
    next_state = state;
    if (state == MON_RUN) begin
      if (MemWrite) begin
        if (DataAdr == TOHOST_ADDR) begin
          next_state = (WriteData == 32'd1) ? MON_PASS : MON_FAIL;
        end else if (DataAdr != SCRATCH_ADDR) begin
          next_state = MON_FAIL;
        end
      end
      if ((next_state == MON_RUN) && wd_expire) begin
        next_state = MON_TIMEOUT;
      end
    end
  end

  always_comb begin
    run_cnt_en = 1'b0;
    scratch_en = 1'b0;
    capture    = 1'b0;
    if (state == MON_RUN) begin
      run_cnt_en = (next_state == MON_RUN);
      scratch_en = MemWrite && (DataAdr == SCRATCH_ADDR);
      capture    = (next_state == MON_FAIL);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_adr  <= '0;
      err_data <= '0;
    end else if (capture) begin
      err_adr  <= DataAdr;
      err_data <= WriteData;
    end
  end

  assign status = state;

  mon_sat_counter #(.W(CNT_W)) u_cycles (
    .clk     (clk),
    .clear_n (reset),
    .en      (run_cnt_en),
    .count   (cycles)
  );

  mon_sat_counter #(.W(16)) u_scratch (
    .clk     (clk),
    .clear_n (reset),
    .en      (scratch_en),
    .count   (scratch_stores)
  );

endmodule

// File: tb/tb_mmio_test_monitor.sv
// Directed plus randomized bench for mmio_test_monitor against a cycle-level reference model.
module tb_mmio_test_monitor;

  localparam int TO = 20;
`ifdef MMIO_MON_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done;
  logic [1:0]  status;
  logic [31:0] err_adr;
  logic [31:0] err_data;
  logic [31:0] cycles;
  logic [15:0] scratch_stores;

  int tests = 0;
  int fails = 0;

  // Reference model: status 0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT.
  int unsigned m_status;
  logic [31:0] m_cycles;
  int unsigned m_scratch;
  logic [31:0] m_err_adr;
  logic [31:0] m_err_data;

  mmio_test_monitor #(
    .TOHOST_ADDR    (32'd32),
    .SCRATCH_ADDR   (32'd16),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWrite       (MemWrite),
    .DataAdr        (DataAdr),
    .WriteData      (WriteData),
    .done           (done),
    .status         (status),
    .err_adr        (err_adr),
    .err_data       (err_data),
    .cycles         (cycles),
    .scratch_stores (scratch_stores)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input logic rst, input logic mw,
                                     input logic [31:0] a, input logic [31:0] d);
    bit term;
    term = 1'b0;
    if (!rst) begin
      m_status   = 0;
      m_cycles   = '0;
      m_scratch  = 0;
      m_err_adr  = '0;
      m_err_data = '0;
    end else if (m_status == 0) begin
      if (mw) begin
        if (a == 32'd32) begin
          term = 1'b1;
          if (d == 32'd1) begin
            m_status = 1;
          end else begin
            m_status   = 2;
            m_err_adr  = a;
            m_err_data = d;
          end
        end else if (a == 32'd16) begin
          if (m_scratch < 65535) m_scratch = m_scratch + 1;
        end else begin
          term       = 1'b1;
          m_status   = 2;
          m_err_adr  = a;
          m_err_data = d;
        end
      end
      if (!term && WD && (m_cycles == 32'(TO - 1))) begin
        term     = 1'b1;
        m_status = 3;
      end
      if (!term && (m_cycles != 32'hFFFF_FFFF)) m_cycles = m_cycles + 32'd1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".status"},  32'(status),         32'(m_status));
    chk({tag, ".done"},    32'(done),           32'(m_status != 0));
    chk({tag, ".err_adr"}, err_adr,             m_err_adr);
    chk({tag, ".err_dat"}, err_data,            m_err_data);
    chk({tag, ".cycles"},  cycles,              m_cycles);
    chk({tag, ".scratch"}, 32'(scratch_stores), 32'(m_scratch));
  endtask

  // One clock: drive, let the edge sample, advance the model, settle for checking.
  task automatic cyc(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] d);
    reset     = rst;
    MemWrite  = mw;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    model_step(rst, mw, a, d);
    #1;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = $urandom;
    WriteData = $urandom;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;

    repeat (3) cyc(1'b0, 1'b0, '0, '0);
    check_all("reset");
    chk("reset_status", 32'(status), 32'd0);

    repeat (10) idle();
    cyc(1'b1, 1'b1, 32'd32, 32'd1);
    check_all("pass");
    chk("pass_status", 32'(status), 32'd1);
    chk("pass_cycles", cycles, 32'd10);

    cyc(1'b0, 1'b0, '0, '0);
    check_all("reset_after_pass");
    chk("reset_after_pass_done", 32'(done), 32'd0);
    cyc(1'b1, 1'b1, 32'd32, 32'd1);
    check_all("pass_again");

    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 32'd32, 32'd0);
    check_all("fail0");
    chk("fail0_adr", err_adr, 32'd32);
    cyc(1'b1, 1'b1, 32'd32, 32'd1);
    check_all("fail_sticky");
    chk("fail_sticky_status", 32'(status), 32'd2);

    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 32'd16, 32'h0000_ABCD);
    cyc(1'b1, 1'b1, 32'd16, 32'h0000_ABCD);
    check_all("scratch_run");
    cyc(1'b1, 1'b1, 32'd32, 32'd1);
    check_all("scratch_pass");
    chk("scratch_cnt", 32'(scratch_stores), 32'd2);

    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 32'd96, 32'd7);
    check_all("unknown");
    chk("unknown_adr", err_adr, 32'd96);
    chk("unknown_dat", err_data, 32'd7);
    cyc(1'b1, 1'b1, 32'd16, 32'd5);
    check_all("store_after_done");

    cyc(1'b0, 1'b0, '0, '0);
    repeat (TO - 1) idle();
    check_all("wd_pre");
`ifdef MMIO_MON_WATCHDOG_EN
    idle();
    check_all("wd_expire");
    chk("wd_status", 32'(status), 32'd3);
    chk("wd_cycles", cycles, 32'(TO - 1));
`else
    repeat (21) idle();
    check_all("no_wd");
    chk("no_wd_status", 32'(status), 32'd0);
    chk("no_wd_cycles", cycles, 32'd40);
`endif

    cyc(1'b0, 1'b0, '0, '0);
    repeat (TO - 1) idle();
    cyc(1'b1, 1'b1, 32'd32, 32'd1);
    check_all("race");
    chk("race_status", 32'(status), 32'd1);
    chk("race_cycles", cycles, 32'(TO - 1));

    for (int it = 0; it < 30; it++) begin
      cyc(1'b0, 1'b0, '0, '0);
      for (int c = 0; c < 35; c++) begin
        int unsigned r;
        r = $urandom_range(0, 39);
        if (r < 22) begin
          idle();
        end else if (r < 33) begin
          cyc(1'b1, 1'b1, 32'd16, $urandom);
        end else if (r < 35) begin
          cyc(1'b1, 1'b1, 32'd32, ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom);
        end else if (r < 37) begin
          cyc(1'b1, 1'b1, 32'd32, 32'd1);
        end else if (r < 39) begin
          cyc(1'b1, 1'b1, 32'h0000_1000 | $urandom, $urandom);
        end else begin
          cyc(1'b0, 1'b0, $urandom, $urandom);
        end
        check_all("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_test_monitor.md
Name: mmio_test_monitor

Overview:
- Synthesizable end-of-test monitor that consumes the core's data-memory write bus (MemWrite, DataAdr, WriteData).
- Sits directly downstream of `top`, beside data memory, and decodes test-status stores into sticky PASS/FAIL/TIMEOUT status.
- Lets the same regression hex files run on FPGA and in simulation; the bench only polls `done`/`status`.

Parameters:
- TOHOST_ADDR, 32'd32, address of the test-result word (1 = pass, 0 = fail).
- SCRATCH_ADDR, 32'd16, address that tolerates halfword stores (`sh` tests); counted, never terminates.
- TIMEOUT_CYCLES, 100000, watchdog limit in run cycles.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- MemWrite  in  1  store strobe from core.
- DataAdr  in  32  store address.
- WriteData  in  32  store data.
- done  out  1  test finished; sticky.
- status  out  2  0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT.
- err_adr  out  32  DataAdr of the failing store.
- err_data  out  32  WriteData of the failing store.
- cycles  out  CNT_W  run cycles elapsed; frozen at done.
- scratch_stores  out  16  count of SCRATCH_ADDR stores, saturating.

Behaviour:
- Reset (reset == 0 at a rising edge): status = RUN, done = 0, err_adr = 0, err_data = 0, cycles = 0, scratch_stores = 0. Reset mid-run or after done clears everything in the same cycle.
- All bus inputs are sampled at the rising edge. Status updates are visible the cycle after the store, i.e. 1-cycle latency.
- FSM states are RUN, PASS, FAIL, TIMEOUT. Only RUN has exits; PASS, FAIL and TIMEOUT are absorbing until reset.
- In RUN with MemWrite = 1, evaluate in priority order:
  - DataAdr == TOHOST_ADDR and WriteData == 1 -> PASS.
  - DataAdr == TOHOST_ADDR and any other WriteData -> FAIL; capture err_adr/err_data. Data 0 is the normal fail code; other values are FAIL too.
  - DataAdr == SCRATCH_ADDR -> remain RUN; scratch_stores += 1, saturating at 16'hFFFF.
  - Any other address -> FAIL (unknown MemWrite); capture err_adr/err_data.
- In RUN with MemWrite = 0: remain RUN.
- cycles increments every RUN cycle and stops on the transition out of RUN. The transition cycle itself is not counted. No wrap: saturates at all-ones.
- done = (status != RUN), registered.
- Watchdog: if the state is RUN and cycles == TIMEOUT_CYCLES-1 with no terminating store that cycle -> TIMEOUT. err_* stay 0.
- Simultaneous terminating store and watchdog expiry: the store wins (PASS/FAIL).
- Stores after done are ignored: no capture, no scratch count.
- DataAdr/WriteData are don't-care when MemWrite = 0. X on them must not propagate into state.

Optional Feature:
- Macro: MMIO_MON_WATCHDOG_EN.
- Defined: timeout logic as described; status value 3 is reachable.
- Undefined: no watchdog comparator. A test never ends without a TOHOST or unknown store. cycles still counts (saturating); status 3 is unreachable.

Decomposition:
- Package mmio_mon_pkg:
  - typedef enum logic [1:0] mon_status_t {MON_RUN, MON_PASS, MON_FAIL, MON_TIMEOUT}.
  - Default address localparams MON_TOHOST_ADDR = 32 and MON_SCRATCH_ADDR = 16.
- One sub-module: mon_sat_counter (parameterized width, enable, synchronous active-low clear, saturation). Instantiated for cycles and scratch_stores.
- The FSM and capture registers stay in the top module.

Test Plan:
- Reset held 3 cycles, then store (32, 1) at cycle 10 -> next cycle status = PASS, done = 1, cycles = 10, err_* = 0.
- Store (32, 0) -> status = FAIL, err_adr = 32, err_data = 0; a later store (32, 1) leaves status = FAIL.
- Two stores (16, 0xABCD) then (32, 1) -> scratch_stores = 2, status = PASS.
- Store (96, 7) -> status = FAIL, err_adr = 96, err_data = 7.
- With MMIO_MON_WATCHDOG_EN and TIMEOUT_CYCLES = 20:
  - No stores -> status = TIMEOUT after exactly 20 run cycles, cycles = 19.
  - Store (32, 1) on that last cycle -> PASS instead.
- After PASS, drive reset = 0 for 1 cycle -> all outputs return to reset values; then store (32, 1) -> PASS again.
